boot_loader: RTL and testbench
==============================

# boot_loader

Byte-stream program loader sitting directly upstream of the instruction memory of the single-cycle MIPS core. After reset it holds the core in reset, receives a framed program over a byte-wide valid/ready link, assembles big-endian 32-bit instruction words and writes them into instruction memory. It releases the core only once the frame's checksum is verified. A bad frame leaves the core held in reset with a sticky error flag.

## Interface
Parameters:
- MAX_WORDS, 32, instruction-memory depth in words; larger frames are rejected.
- ADDR_BASE, 32'h0, byte address of the first loaded word.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; one clock domain, no other clocks.
- rx_valid  input  1  rx_data holds a byte.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  32  byte address of the write; word aligned.
- imem_wdata  output  32  instruction word being written.
- cpu_reset  output  1  reset to the processor; high until a frame is verified.
- done  output  1  frame loaded and verified.
- error  output  1  frame rejected; sticky until reset.

## Operation
- A byte is accepted on a rising edge where rx_valid && rx_ready. With no accept, no state changes.
- Frame format:
  - N_HI, N_LO: 16-bit big-endian word count N.
  - 4*N data bytes, each word most-significant byte first.
  - One checksum byte: XOR of every preceding frame byte (count bytes plus data bytes).
- FSM states: CNT_HI, CNT_LO, DATA, CHECK, RUN, ERR. Reset state is CNT_HI.
- CNT_HI: accept byte → N[15:8], clear the running XOR, then XOR in the byte → CNT_LO.
- CNT_LO: accept byte → N[7:0].
  - If N > MAX_WORDS → ERR.
  - If N == 0 → CHECK.
  - Otherwise → DATA, with word_index = 0 and byte_index = 0.
- DATA: each accepted byte shifts into a 32-bit assembly register and is XORed into the running checksum.
  - On the 4th byte of a word, register a write: imem_addr = ADDR_BASE + 4*word_index, imem_wdata = assembled word, imem_we = 1 for exactly one cycle; then increment word_index.
  - When word_index reaches N → CHECK.
- CHECK: accepted byte == running XOR → RUN; otherwise → ERR.
- RUN: done = 1, cpu_reset = 0, rx_ready = 0. Incoming bytes are ignored. Terminal until reset.
- ERR: error = 1, cpu_reset = 1, rx_ready = 0. Terminal until reset.
- rx_ready = 1 in CNT_HI, CNT_LO, DATA and CHECK; 0 otherwise.
- Contents of instruction memory are never cleared by this block. A rejected frame may leave partial writes, which is harmless because the core stays in reset.

## Timing
- Reset values: rx_ready = 0 while reset is asserted (1 from the first cycle after release), imem_we = 0, imem_addr = ADDR_BASE, imem_wdata = 0, cpu_reset = 1, done = 0, error = 0.
- All outputs are registered; there are no combinational paths from rx_* to outputs.
- Write latency: imem_we is high in the cycle immediately after the edge that accepts a word's 4th byte.
- Throughput: one byte per cycle when rx_valid is held high; gaps in rx_valid stall without loss.
- The last write strobe always precedes the checksum accept edge by at least one cycle, so memory is complete before the core is released.
- cpu_reset falls and done rises on the same edge that accepts a matching checksum byte. error rises on the edge that accepts the offending byte.
- Reset asserted mid-frame: the FSM returns to CNT_HI immediately and asynchronously, and any pending imem_we is cleared. The next frame starts fresh at ADDR_BASE.
- Counter width rules:
  - word_index is 16 bits.
  - The address uses 32-bit arithmetic, so there is no wrap for N ≤ MAX_WORDS.
  - The count comparison uses the full 16-bit N, so N = 16'hFFFF is rejected rather than wrapping.

## Test plan
- Normal load: stream 00 02 20 08 00 05 01 09 40 20 47 → writes (0x0, 0x20080005) and (0x4, 0x01094020); cpu_reset falls and done = 1 on the edge accepting 0x47.
- Empty frame: 00 00 00 → no imem_we pulses; done = 1 after the 3rd byte.
- Oversize: 00 21 with MAX_WORDS = 32 → error = 1 after the 2nd byte; rx_ready = 0; cpu_reset stays 1; no writes.
- Bad checksum: the normal-load stream with the last byte 0x46 → both writes occur, then error = 1, done = 0, cpu_reset = 1.
- Backpressure and idle: the normal-load stream with rx_valid low on alternate cycles → identical writes and result. Bytes sent after done produce no writes and no state change.
- Reset mid-load: assert reset after the 6th byte of the normal load → outputs take reset values immediately. Resend the full frame → writes start again at address 0x0 and done = 1.

Source files
------------

// File: rtl/boot_loader_if.sv
// Byte-stream receive link plus instruction-memory write port and core-release status
// of the program loader, bundled so the loader and its environment share one port.
interface boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// Receives a framed program (16-bit word count, big-endian words, XOR checksum), writes it
// into instruction memory and releases the core only once the checksum matches.
module boot_loader #(
    parameter int          MAX_WORDS = 32,
    parameter logic [31:0] ADDR_BASE = 32'h0
) (
    input  logic         clk,
    input  logic         reset,
    boot_loader_if.slave bus
);
    typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, CHECK, RUN, ERR} state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] shift_q, shift_d;
    logic        rx_ready_q, rx_ready_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        accept;
    logic [15:0] n_full;
    logic [15:0] word_idx_inc;

    assign accept       = bus.rx_valid && rx_ready_q;
    assign n_full       = {n_q[15:8], bus.rx_data};
    assign word_idx_inc = word_idx_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        csum_d       = csum_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            CNT_HI: if (accept) begin
                n_d     = {bus.rx_data, 8'h00};
                csum_d  = bus.rx_data;
                state_d = CNT_LO;
            end
            CNT_LO: if (accept) begin
                n_d    = n_full;
                csum_d = csum_q ^ bus.rx_data;
                // Full 16-bit compare so huge counts are rejected instead of wrapping.
                if ({16'h0, n_full} > 32'(MAX_WORDS)) begin
                    state_d = ERR;
                end else if (n_full == 16'd0) begin
                    state_d = CHECK;
                end else begin
                    state_d    = DATA;
                    word_idx_d = 16'd0;
                    byte_idx_d = 2'd0;
                end
            end
            DATA: if (accept) begin
                csum_d     = csum_q ^ bus.rx_data;
                shift_d    = {shift_q[15:0], bus.rx_data};
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ADDR_BASE + {14'h0, word_idx_q, 2'b00};
                    imem_wdata_d = {shift_q, bus.rx_data};
                    word_idx_d   = word_idx_inc;
                    if (word_idx_inc == n_q) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: if (accept) begin
                state_d = (bus.rx_data == csum_q) ? RUN : ERR;
            end
            default: ;
        endcase

        rx_ready_d  = (state_d == CNT_HI) || (state_d == CNT_LO) ||
                      (state_d == DATA)   || (state_d == CHECK);
        cpu_reset_d = (state_d != RUN);
        done_d      = (state_d == RUN);
        error_d     = (state_d == ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= CNT_HI;
            n_q          <= 16'd0;
            csum_q       <= 8'h00;
            word_idx_q   <= 16'd0;
            byte_idx_q   <= 2'd0;
            shift_q      <= 24'h0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= ADDR_BASE;
            imem_wdata_q <= 32'h0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            csum_q       <= csum_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table of frames, timing sequences and random frames
// compared against a frame-level reference model.
module tb_boot_loader;
    localparam int          MAX_WORDS = 32;
    localparam logic [31:0] ADDR_BASE = 32'h0;
    localparam logic [87:0] NORM      = 88'h00_02_20_08_00_05_01_09_40_20_47;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        string        name;
        logic [127:0] bytes;
        int           len;
        int           gap_mode;
        bit           exp_done;
        bit           exp_err;
        int           exp_nw;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    boot_loader_if bus ();

    boot_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_BASE(ADDR_BASE)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          m_done;
    bit          m_err;
    vec_t        tbl[8];

    always @(negedge clk) begin
        if (!reset && bus.imem_we) begin
            got_addr.push_back(bus.imem_addr);
            got_data.push_back(bus.imem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Asserts reset mid-cycle, checks the asynchronous reset values, then releases.
    task automatic do_reset();
        bus.rx_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_imem_addr", bus.imem_addr, ADDR_BASE);
        check("rst_imem_wdata", bus.imem_wdata, 32'h0);
        check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        @(negedge clk);
        got_addr.delete();
        got_data.delete();
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; presents one byte for one cycle after 'gap' idle cycles.
    task automatic drive(input logic [7:0] b, input int gap, output bit acc);
        for (int g = 0; g < gap; g++) begin
            bus.rx_valid = 1'b0;
            @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        acc          = bus.rx_ready;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t q, input int gap_mode);
        bit acc;
        int gap;
        foreach (q[i]) begin
            gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            drive(q[i], gap, acc);
            if (!acc) break;
        end
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic bq_t unpack_bytes(input logic [127:0] v, input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(v[127 - 8*i -: 8]);
        return q;
    endfunction

    // Frame-level model: what a correct loader writes and how the frame ends.
    task automatic model(input bq_t q);
        int n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (q.size() < 2) return;
        n = int'(q[0]) * 256 + int'(q[1]);
        if (n > MAX_WORDS) begin
            m_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (2 + 4*i + 3 < q.size()) begin
                exp_addr.push_back(ADDR_BASE + 32'(4*i));
                exp_data.push_back({q[2+4*i], q[3+4*i], q[4+4*i], q[5+4*i]});
            end
        end
        if (q.size() >= 4*n + 3) begin
            x = 8'h00;
            for (int i = 0; i < 4*n + 2; i++) x = x ^ q[i];
            if (q[4*n+2] == x) m_done = 1'b1;
            else m_err = 1'b1;
        end
    endtask

    task automatic check_result(input string name, input bit e_done, input bit e_err, input int e_nw);
        int nmin;
        check({name, "_done"}, 32'(bus.done), 32'(e_done));
        check({name, "_error"}, 32'(bus.error), 32'(e_err));
        check({name, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(!e_done));
        check({name, "_rx_ready"}, 32'(bus.rx_ready), 32'(!(e_done || e_err)));
        check({name, "_nwrites"}, 32'(got_addr.size()), 32'(e_nw));
        nmin = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("%s_addr%0d", name, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
        end
    endtask

    initial begin
        bq_t q;
        bit acc;
        int n;
        logic [7:0] x;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        tbl[0] = '{"normal",    {NORM, 40'h0},                   11, 0, 1'b1, 1'b0, 2};
        tbl[1] = '{"empty",     {24'h000000, 104'h0},            3,  0, 1'b1, 1'b0, 0};
        tbl[2] = '{"oversize",  {32'h0021_AABB, 96'h0},          4,  0, 1'b0, 1'b1, 0};
        tbl[3] = '{"badsum",    {NORM[87:8], 8'h46, 40'h0},      11, 0, 1'b0, 1'b1, 2};
        tbl[4] = '{"altgap",    {NORM, 40'h0},                   11, 1, 1'b1, 1'b0, 2};
        tbl[5] = '{"afterdone", {NORM, 16'hAABB, 24'h0},         13, 0, 1'b1, 1'b0, 2};
        tbl[6] = '{"ffff",      {24'hFFFF00, 104'h0},            3,  0, 1'b0, 1'b1, 0};
        tbl[7] = '{"oneword",   {56'h0001DEADBEEF23, 72'h0},     7,  2, 1'b1, 1'b0, 1};

        repeat (2) @(negedge clk);

        foreach (tbl[t]) begin
            do_reset();
            q = unpack_bytes(tbl[t].bytes, tbl[t].len);
            model(q);
            send_frame(q, tbl[t].gap_mode);
            check_result(tbl[t].name, tbl[t].exp_done, tbl[t].exp_err, tbl[t].exp_nw);
            $display("vector %s: done=%0d error=%0d writes=%0d", tbl[t].name, bus.done, bus.error, got_addr.size());
        end

        // Cycle-exact write latency and release timing on the normal frame.
        do_reset();
        q = unpack_bytes({NORM, 40'h0}, 11);
        for (int i = 0; i < 5; i++) drive(q[i], 0, acc);
        drive(q[5], 0, acc);
        check("lat_we_first", 32'(bus.imem_we), 32'd1);
        check("lat_addr_first", bus.imem_addr, 32'h0);
        check("lat_data_first", bus.imem_wdata, 32'h20080005);
        drive(q[6], 0, acc);
        check("lat_we_oneshot", 32'(bus.imem_we), 32'd0);
        for (int i = 7; i < 10; i++) drive(q[i], 0, acc);
        check("lat_we_second", 32'(bus.imem_we), 32'd1);
        check("lat_addr_second", bus.imem_addr, 32'h4);
        check("lat_data_second", bus.imem_wdata, 32'h01094020);
        check("pre_sum_done", 32'(bus.done), 32'd0);
        check("pre_sum_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        drive(q[10], 0, acc);
        check("sum_edge_done", 32'(bus.done), 32'd1);
        check("sum_edge_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        check("sum_edge_rx_ready", 32'(bus.rx_ready), 32'd0);
        drive(8'hAA, 0, acc);
        check("post_done_refused", 32'(acc), 32'd0);
        check("post_done_nwrites", 32'(got_addr.size()), 32'd2);
        $display("sequence latency: writes=%0d done=%0d", got_addr.size(), bus.done);

        // Error rises on the edge that accepts the oversize count byte.
        do_reset();
        drive(8'h00, 0, acc);
        drive(8'h21, 0, acc);
        check("over_edge_error", 32'(bus.error), 32'd1);
        check("over_edge_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("over_edge_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        $display("sequence oversize: error=%0d", bus.error);

        // Reset while the first write strobe is pending, then a clean reload.
        do_reset();
        for (int i = 0; i < 6; i++) drive(q[i], 0, acc);
        check("mid_we_pending", 32'(bus.imem_we), 32'd1);
        do_reset();
        model(q);
        send_frame(q, 0);
        check_result("reload", 1'b1, 1'b0, 2);
        $display("sequence reset-mid-load: writes=%0d done=%0d", got_addr.size(), bus.done);

        // Random frames against the model.
        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = MAX_WORDS;
                2:       n = MAX_WORDS + 1;
                3:       n = int'($urandom_range(MAX_WORDS + 2, 65535));
                default: n = int'($urandom_range(1, 6));
            endcase
            q.delete();
            q.push_back(8'(n >> 8));
            q.push_back(8'(n));
            if (n <= MAX_WORDS) begin
                for (int i = 0; i < 4*n; i++) q.push_back(8'($urandom));
                x = 8'h00;
                foreach (q[i]) x = x ^ q[i];
                if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                q.push_back(x);
            end
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) q.push_back(8'($urandom));
            do_reset();
            model(q);
            send_frame(q, int'($urandom_range(0, 2)));
            check_result($sformatf("rand%0d", r), m_done, m_err, exp_addr.size());
            $display("random %0d: N=%0d done=%0d error=%0d writes=%0d", r, n, bus.done, bus.error, got_addr.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
